gate_stim_checker: RTL and testbench
====================================

Name: gate_stim_checker

Overview:
Self-checking stimulus/response block for 2-input combinational gate DUTs. It drives the DUT inputs through every {a,b} combination and samples the DUT output after a programmable settle time. Each sample is compared against a parameterised truth table, and the block reports pass/fail, an error count and the first failing vector. It sits opposite a gate DUT in synthesisable self-test and simulation harnesses, and replaces hand-written stimulus blocks and $monitor inspection.

Parameters:
TT, 4'b1110, expected DUT output indexed by {a,b}; bit k is the expected c for {a,b}=k; the default is OR
SETTLE, 2, cycles to wait after applying a vector before sampling; legal range >=1
PASSES, 1, number of full 4-vector sweeps per run; legal range >=1
ERR_W, 8, width of the error counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, level-sampled in IDLE only
stim_a  out  1  DUT input a (registered)
stim_b  out  1  DUT input b (registered)
dut_c  in  1  DUT output under check
busy  out  1  high from APPLY through CHECK of the final vector
done  out  1  one-cycle pulse at the end of a run
pass  out  1  1 when the last run had zero mismatches; held until the next start
err_count  out  ERR_W  mismatch count of the last or current run; saturating
fail_vec  out  2  {a,b} of the first mismatch in the run
fail_valid  out  1  fail_vec holds a captured value

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; stim_a, stim_b, busy, done, pass, fail_valid = 0; err_count = 0; fail_vec = 0; vector index and pass and settle counters = 0.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: stim outputs driven 0; busy=0. If start=1 at a rising edge:
  - clear err_count, fail_valid, fail_vec, pass;
  - idx=0, pass counter=0;
  - load {stim_a,stim_b}=2'b00;
  - go to APPLY.
- APPLY: one cycle; settle counter=0; go to SETTLE.
- SETTLE: stay for exactly SETTLE cycles (counter 0..SETTLE-1), then go to CHECK.
- CHECK: sample dut_c and compare with TT[idx].
  - On mismatch: err_count+1, saturating at 2^ERR_W-1.
  - On mismatch with fail_valid=0: fail_vec=idx and fail_valid=1. Later mismatches do not overwrite fail_vec.
  - If idx<3: idx+1, load stim={idx+1}, go to APPLY.
  - If idx==3 and the pass counter is below PASSES-1: idx=0, pass counter+1, load stim=00, go to APPLY.
  - Otherwise go to DONE. pass=1 only if err_count==0 including this final compare (same-edge update).
- DONE: done=1 and busy=0 for this cycle only; stim driven 0; next state is IDLE.
- Timing:
  - Each vector occupies SETTLE+2 cycles.
  - The edge that samples start is edge 0.
  - done is high in the cycle after edge 4*PASSES*(SETTLE+2). With the defaults this is edge 16.
  - busy is high from edge 0 to edge 4*PASSES*(SETTLE+2).
- start while busy or in DONE: ignored. A start held high continuously begins a new run at the first IDLE edge, so runs are spaced by one IDLE cycle.
- Reset mid-run: immediate return to the reset values; the run is abandoned with no done pulse. A fresh start is required after rst_n rises.
- X or Z on dut_c at CHECK counts as a mismatch (case-inequality compare in simulation).
- err_count, pass, fail_vec and fail_valid hold their values after DONE until the next accepted start or reset.

Test Plan:
1. OR DUT, defaults, single start pulse -> stim 00,01,10,11, each held 4 cycles; done pulses once at edge 16; pass=1, err_count=0, fail_valid=0.
2. dut_c tied 0, defaults -> err_count=3, fail_vec=2'b01, fail_valid=1, pass=0, done at edge 16.
3. AND DUT with TT=4'b1110 -> mismatches at 01 and 10 only; err_count=2, fail_vec=2'b01, pass=0.
4. start pulsed at edges 5 and 16, then held high from edge 20 -> no restart during the run; second run's edge 0 is edge 20 (IDLE first sees start there), second done at edge 36; busy low exactly at edges 16-20 and 36.
5. rst_n asserted between edges 9 and 10, released at edge 12 -> all outputs 0 asynchronously, no done pulse; the block stays IDLE until the next start.
6. ERR_W=2, PASSES=4, dut_c tied 0 -> 12 mismatches; err_count saturates at 3; fail_vec=01; done at edge 64; pass=0.

Source files
------------

// File: rtl/gate_stim_checker.sv
// Stimulus/response checker for a 2-input combinational gate: sweeps {a,b},
// waits a settle time, compares the gate output against a truth table and reports the result.
module gate_stim_checker #(
   parameter logic [3:0] TT     = 4'b1110,
   parameter int         SETTLE = 2,
   parameter int         PASSES = 1,
   parameter int         ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             stim_a,
   output logic             stim_b,
   input  logic             dut_c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       fail_vec,
   output logic             fail_valid
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PCW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SCW-1:0] SET_LAST  = SCW'(SETTLE - 1);
   localparam logic [PCW-1:0] PASS_LAST = PCW'(PASSES - 1);

   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [1:0]     idx;
   logic [SCW-1:0] settle_cnt;
   logic [PCW-1:0] pass_cnt;
   logic           mismatch;
   logic           last_vec;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Case inequality so that an undriven or X gate output is flagged as a mismatch.
   assign mismatch = (dut_c !== TT[idx]);
   assign last_vec = (idx == 2'd3) && (pass_cnt == PASS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nxt = S_APPLY;
         S_APPLY:  begin
            busy      = 1'b1;
            state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == SET_LAST) state_nxt = S_CHECK;
         end
         S_CHECK:  begin
            busy      = 1'b1;
            state_nxt = last_vec ? S_DONE : S_APPLY;
         end
         S_DONE:   begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_a     <= 1'b0;
         stim_b     <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= 2'b00;
         fail_valid <= 1'b0;
         idx        <= 2'd0;
         settle_cnt <= '0;
         pass_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               {stim_a, stim_b} <= 2'b00;
               if (start) begin
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= 2'b00;
                  pass       <= 1'b0;
                  idx        <= 2'd0;
                  pass_cnt   <= '0;
               end
            end
            S_APPLY:  settle_cnt <= '0;
            S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
            S_CHECK: begin
               if (mismatch) begin
                  err_count <= sat_inc(err_count);
                  if (!fail_valid) begin
                     fail_vec   <= idx;
                     fail_valid <= 1'b1;
                  end
               end
               if (idx != 2'd3) begin
                  idx              <= idx + 2'd1;
                  {stim_a, stim_b} <= idx + 2'd1;
               end else if (pass_cnt != PASS_LAST) begin
                  idx              <= 2'd0;
                  pass_cnt         <= pass_cnt + 1'b1;
                  {stim_a, stim_b} <= 2'b00;
               end else begin
                  {stim_a, stim_b} <= 2'b00;
                  // The final compare is folded in on the same edge.
                  pass             <= (err_count == '0) && !mismatch;
               end
            end
            S_DONE:   {stim_a, stim_b} <= 2'b00;
            default:  {stim_a, stim_b} <= 2'b00;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: a default instance and a 4-pass / 2-bit-counter instance,
// each facing a table-driven gate model.
module tb_gate_stim_checker;

   localparam logic [3:0] TT0 = 4'b1110;
   localparam int         S   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start0 = 1'b0, start1 = 1'b0;
   logic [3:0] resp0 = 4'b1110, resp1 = 4'b1110;
   logic       a0, b0, c0, busy0, done0, pass0, fvld0;
   logic       a1, b1, c1, busy1, done1, pass1, fvld1;
   logic [7:0] err0;
   logic [1:0] err1;
   logic [1:0] fv0, fv1;

   assign c0 = resp0[{a0, b0}];
   assign c1 = resp1[{a1, b1}];

   gate_stim_checker dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .stim_a(a0), .stim_b(b0), .dut_c(c0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0),
      .fail_valid(fvld0));

   gate_stim_checker #(.PASSES(4), .ERR_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stim_a(a1), .stim_b(b1), .dut_c(c1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1),
      .fail_valid(fvld1));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] resp;
      int         err;
      int         fv;
      int         fvld;
      int         pass;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sample(input int sel, output int ab, output int busy, output int done,
                         output int pass, output int err, output int fv, output int fvld);
      if (sel == 0) begin
         ab = {a0, b0}; busy = busy0; done = done0; pass = pass0;
         err = err0; fv = fv0; fvld = fvld0;
      end else begin
         ab = {a1, b1}; busy = busy1; done = done1; pass = pass1;
         err = err1; fv = fv1; fvld = fvld1;
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start0 = v;
      else          start1 = v;
   endtask

   // Expected outcome of a whole run from the gate's response table alone.
   task automatic model(input logic [3:0] resp, input int passes, input int errw,
                        output int e, output int fv, output int fvld, output int pass);
      int n = 0;
      int maxv = (1 << errw) - 1;
      fv = 0;
      fvld = 0;
      for (int k = 0; k < 4; k++) begin
         if (resp[k] != TT0[k]) begin
            n++;
            if (fvld == 0) begin
               fv = k;
               fvld = 1;
            end
         end
      end
      e = n * passes;
      if (e > maxv) e = maxv;
      pass = (n == 0) ? 1 : 0;
   endtask

   task automatic run(input string name, input int sel, input logic [3:0] resp, input int passes,
                      input int ee, input int efv, input int efvld, input int epass);
      int n, bad, dcnt, dat;
      int ab, bs, dn, ps, er, fv, fl;
      if (sel == 0) resp0 = resp;
      else          resp1 = resp;
      n = 4 * passes * (S + 2);
      bad = 0; dcnt = 0; dat = -1;
      set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
      for (int e = 0; e <= n + 2; e++) begin
         sample(sel, ab, bs, dn, ps, er, fv, fl);
         if (bs != ((e < n) ? 1 : 0)) bad++;
         if (ab != ((e < n) ? ((e / (S + 2)) % 4) : 0)) bad++;
         if (dn != 0) begin
            dcnt++;
            dat = e;
         end
         tick();
      end
      sample(sel, ab, bs, dn, ps, er, fv, fl);
      chk({name, " seq"}, bad, 0);
      chk({name, " done_cnt"}, dcnt, 1);
      chk({name, " done_edge"}, dat, n);
      chk({name, " err_count"}, er, ee);
      chk({name, " fail_vec"}, fv, efv);
      chk({name, " fail_valid"}, fl, efvld);
      chk({name, " pass"}, ps, epass);
   endtask

   initial begin
      int ab, bs, dn, ps, er, fv, fl;
      int me, mfv, mfl, mps;
      int bad, dcnt;
      logic [3:0] r;

      tbl[0] = '{4'b1110, 0, 0, 0, 1};
      tbl[1] = '{4'b0000, 3, 1, 1, 0};
      tbl[2] = '{4'b1000, 2, 1, 1, 0};
      tbl[3] = '{4'b1111, 1, 0, 1, 0};
      tbl[4] = '{4'b0001, 4, 0, 1, 0};
      tbl[5] = '{4'b0110, 1, 3, 1, 0};
      tbl[6] = '{4'b0111, 2, 0, 1, 0};
      tbl[7] = '{4'b1100, 1, 1, 1, 0};

      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sample(s, ab, bs, dn, ps, er, fv, fl);
         chk($sformatf("reset%0d outputs", s), ab + bs + dn + ps + er + fv + fl, 0);
      end
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++)
         run($sformatf("tbl%0d", i), 0, tbl[i].resp, 1,
             tbl[i].err, tbl[i].fv, tbl[i].fvld, tbl[i].pass);

      // Restart ignored while busy; a held start relaunches from IDLE.
      resp0 = 4'b1110;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      bad = 0; dcnt = 0;
      for (int e = 0; e <= 40; e++) begin
         int eb, ev, nx;
         sample(0, ab, bs, dn, ps, er, fv, fl);
         eb = ((e < 16) || (e >= 20 && e < 36)) ? 1 : 0;
         ev = (e < 16) ? ((e / 4) % 4) : ((e >= 20 && e < 36) ? (((e - 20) / 4) % 4) : 0);
         if (bs != eb || ab != ev) bad++;
         if (dn != ((e == 16 || e == 36) ? 1 : 0)) bad++;
         if (dn != 0) dcnt++;
         nx = e + 1;
         start0 = ((nx == 5) || (nx == 16) || (nx >= 20 && nx <= 36)) ? 1'b1 : 1'b0;
         tick();
      end
      start0 = 1'b0;
      chk("restart seq", bad, 0);
      chk("restart done_cnt", dcnt, 2);
      sample(0, ab, bs, dn, ps, er, fv, fl);
      chk("restart pass", ps, 1);

      // Reset in the middle of a failing run.
      resp0 = 4'b0000;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (9) tick();
      sample(0, ab, bs, dn, ps, er, fv, fl);
      chk("prereset err_count", er, 1);
      #2 rst_n = 1'b0;
      #1;
      sample(0, ab, bs, dn, ps, er, fv, fl);
      chk("midreset outputs", ab + bs + dn + ps + er + fv + fl, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int e = 0; e < 10; e++) begin
         tick();
         sample(0, ab, bs, dn, ps, er, fv, fl);
         if (ab != 0 || bs != 0 || dn != 0 || er != 0 || fl != 0) bad++;
      end
      chk("postreset idle", bad, 0);
      run("after_reset", 0, 4'b1000, 1, 2, 1, 1, 0);

      // Multi-pass instance with a narrow saturating counter.
      run("sat_zero", 1, 4'b0000, 4, 3, 1, 1, 0);
      run("multi_or", 1, 4'b1110, 4, 0, 0, 0, 1);
      run("multi_xor", 1, 4'b0110, 4, 3, 3, 1, 0);

      for (int i = 0; i < 8; i++) begin
         r = 4'($urandom_range(0, 15));
         model(r, 1, 8, me, mfv, mfl, mps);
         run($sformatf("rnd0_%0d", i), 0, r, 1, me, mfv, mfl, mps);
      end
      for (int i = 0; i < 3; i++) begin
         r = 4'($urandom_range(0, 15));
         model(r, 4, 2, me, mfv, mfl, mps);
         run($sformatf("rnd1_%0d", i), 1, r, 4, me, mfv, mfl, mps);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
